// File: rtl/uart_rx_check.sv
`timescale 1ns/1ps
// uart_rx_check
// -----------------------------------------------------------------------------
// 8N1 UART receiver running at a fixed number of clocks per bit. It has an
// optional checker that confirms received bytes follow the incrementing
// 0,1,2,...,255,0 pattern. This pattern is used for loopback bring-up.
//
// Build option:
//   SEQ_CHECK_EN  when defined, an internal "expected" byte tracks the
//                 incrementing pattern and drives seq_err; otherwise seq_err
//                 is tied low.
//
// Parameters:
//   Baut       clocks per bit (4..511), default 434 = 50 MHz / 115200
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   rxd        serial line, idle high, asynchronous to clk
//   data       last good byte received, held between frames
//   valid      one-cycle pulse when data is updated
//   frame_err  one-cycle pulse when the stop bit samples low
//   seq_err    one-cycle pulse, coincident with valid, on a sequence mismatch
// -----------------------------------------------------------------------------
module uart_rx_check #(
  parameter int Baut = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       seq_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // START samples mid-bit; DATA and STOP sample one full bit later each time.
  localparam logic [8:0] HALF_M1 = 9'(Baut / 2 - 1);
  localparam logic [8:0] FULL_M1 = 9'(Baut - 1);

  logic       rx_s1, rx_s2, rx_d;
  state_t     state_r, state_s;
  logic [8:0] cnt_r, cnt_s;
  logic [2:0] idx_r, idx_s;
  logic [7:0] shift_r, shift_s;
  logic [7:0] data_s;
  logic       valid_s, frame_err_s, seq_err_s;
  logic       start_edge_s;

  assign start_edge_s = rx_d & ~rx_s2;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Next-state and datapath logic for the receive state machine.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    shift_s     = shift_r;
    data_s      = data;
    valid_s     = 1'b0;
    frame_err_s = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = 9'd0;
        if (start_edge_s) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_M1) begin
          cnt_s = 9'd0;
          idx_s = 3'd0;
          // A line back high at mid-start-bit is a glitch, not a frame.
          if (!rx_s2) begin
            state_s = DATA;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + 9'd1;
        end
      end
      DATA: begin
        if (cnt_r == FULL_M1) begin
          cnt_s   = 9'd0;
          shift_s = {rx_s2, shift_r[7:1]};
          if (idx_r == 3'd7) begin
            state_s = STOP;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + 9'd1;
        end
      end
      STOP: begin
        if (cnt_r == FULL_M1) begin
          cnt_s   = 9'd0;
          state_s = IDLE;
          if (rx_s2) begin
            data_s  = shift_r;
            valid_s = 1'b1;
          end else begin
            frame_err_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + 9'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 9'd0;
        idx_s   = 3'd0;
      end
    endcase
  end

  // State machine and datapath registers; all outputs are registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= IDLE;
      cnt_r     <= 9'd0;
      idx_r     <= 3'd0;
      shift_r   <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      shift_r   <= shift_s;
      data      <= data_s;
      valid     <= valid_s;
      frame_err <= frame_err_s;
      seq_err   <= seq_err_s;
    end
  end

`ifdef SEQ_CHECK_EN
  logic [7:0] expected_r, expected_s;

  // Compare each good byte against the tracked value, then resync to byte+1
  // so a single dropped byte produces exactly one error.
  always_comb begin
    seq_err_s  = 1'b0;
    expected_s = expected_r;
    if (valid_s) begin
      seq_err_s  = (data_s != expected_r);
      expected_s = data_s + 8'd1;
    end else begin
      expected_s = expected_r;
    end
  end

  // Expected-byte register of the sequence checker.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      expected_r <= 8'h00;
    end else begin
      expected_r <= expected_s;
    end
  end
`else
  assign seq_err_s = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_check.sv
`timescale 1ns/1ps
// Testbench for uart_rx_check: a small-Baut instance for functional
// sequences and a default-Baut instance for exact edge timing.
module tb_uart_rx_check;

  localparam int B  = 16;
  localparam int BL = 434;
`ifdef SEQ_CHECK_EN
  localparam logic SEQ_ON = 1'b1;
`else
  localparam logic SEQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       rxd, rxd_l;
  logic [7:0] data, data_l;
  logic       valid, frame_err, seq_err;
  logic       valid_l, frame_err_l, seq_err_l;

  uart_rx_check #(.Baut(B)) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .data(data),
    .valid(valid), .frame_err(frame_err), .seq_err(seq_err)
  );

  uart_rx_check dut_l (
    .clk(clk), .rstn(rstn), .rxd(rxd_l), .data(data_l),
    .valid(valid_l), .frame_err(frame_err_l), .seq_err(seq_err_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       f;
    logic       s;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_seq;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_cyc = -1;
  int   b2b_cnt = 0;
  int   p_l = 0;
  bit   b2b = 1'b0;
  exp_t sbq[$];
  exp_t e_m;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input bit l, input logic v);
    if (l) rxd_l = v;
    else   rxd   = v;
  endtask

  // Caller must be at posedge+1; returns at posedge+1.
  task automatic send(input bit l, input logic [7:0] b, input logic stop);
    int bt;
    bt = l ? BL : B;
    drive(l, 1'b0);
    repeat (bt) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      drive(l, b[i]);
      repeat (bt) @(posedge clk);
      #1;
    end
    drive(l, stop);
    repeat (bt) @(posedge clk);
    #1;
    drive(l, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: pops the scoreboard on every pulse of the small instance.
  initial forever begin
    @(negedge clk);
    if (valid_l || frame_err_l) p_l++;
    if (valid && frame_err) begin
      checks++; errors++;
      $display("FAIL exclusive valid=%0b frame_err=%0b required one", valid, frame_err);
    end else if (valid || frame_err) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse valid=%0b frame_err=%0b data=%0h required none", valid, frame_err, data);
      end else begin
        e_m = sbq.pop_front();
        checks++;
        if (frame_err !== e_m.f || valid !== !e_m.f ||
            (!e_m.f && (data !== e_m.d || seq_err !== e_m.s))) begin
          errors++;
          $display("FAIL pulse actual v=%0b fe=%0b d=%0h se=%0b required fe=%0b d=%0h se=%0b",
                   valid, frame_err, data, seq_err, e_m.f, e_m.d, e_m.s);
        end
      end
      if (valid && b2b) begin
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != 10 * B) begin
            errors++;
            $display("FAIL spacing actual=%0d required=%0d", cyc - last_cyc, 10 * B);
          end
        end
        last_cyc = cyc;
        b2b_cnt++;
      end
    end else if (seq_err) begin
      checks++; errors++;
      $display("FAIL seq_err_alone actual=1 required=0");
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0, 1'b1};
    tbl[1] = '{8'h3C, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[3] = '{8'h01, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[4] = '{8'h03, 1'b1, 8'h03, 1'b0, 1'b1};
    tbl[5] = '{8'h04, 1'b1, 8'h04, 1'b0, 1'b0};

    rstn = 1'b0; rxd = 1'b1; rxd_l = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", {24'd0, data}, 32'h00);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_seq_err", {31'd0, seq_err}, 32'd0);
    rstn = 1'b1;
    idle(2);

    // Exact edge timing at the default rate.
    fork
      send(1'b1, 8'hA5, 1'b1);
      begin
        repeat (4125) @(posedge clk);
        #1;
        chk("l_valid_before", {31'd0, valid_l}, 32'd0);
        @(posedge clk); #1;
        chk("l_valid_4126", {31'd0, valid_l}, 32'd1);
        chk("l_data_4126", {24'd0, data_l}, 32'hA5);
        chk("l_ferr_4126", {31'd0, frame_err_l}, 32'd0);
        @(posedge clk); #1;
        chk("l_valid_after", {31'd0, valid_l}, 32'd0);
      end
    join
    idle(10);
    drive(1'b1, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    drive(1'b1, 1'b1);
    idle(1000);
    chk("l_glitch_pulses", p_l, 32'd1);
    send(1'b1, 8'h55, 1'b1);
    idle(50);
    chk("l_pulses_55", p_l, 32'd2);
    chk("l_data_55", {24'd0, data_l}, 32'h55);

    // Table-driven frames on the small instance.
    for (int i = 0; i < 6; i++) begin
      sbq.push_back('{tbl[i].exp_data, tbl[i].exp_ferr, tbl[i].exp_seq & SEQ_ON});
      send(1'b0, tbl[i].b, tbl[i].stop);
      idle(2 * B);
      chk($sformatf("tbl%0d_data", i), {24'd0, data}, {24'd0, tbl[i].exp_data});
    end

    // Glitch shorter than half a bit, then a good frame.
    drive(1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    drive(1'b0, 1'b1);
    idle(4 * B);
    sbq.push_back('{8'h55, 1'b0, SEQ_ON});
    send(1'b0, 8'h55, 1'b1);
    idle(2 * B);
    chk("glitch_data", {24'd0, data}, 32'h55);

    // Back-to-back incrementing sequence from reset.
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(2);
    chk("rst2_data", {24'd0, data}, 32'h00);
    b2b = 1'b1;
    for (int i = 0; i < 300; i++) begin
      sbq.push_back('{8'(i), 1'b0, 1'b0});
      send(1'b0, 8'(i), 1'b1);
    end
    idle(2 * B);
    b2b = 1'b0;
    chk("b2b_count", b2b_cnt, 32'd300);
    chk("b2b_last_data", {24'd0, data}, 32'h2B);

    // Reset during data bit 4 of 0xFF.
    drive(1'b0, 1'b0);
    repeat (B) @(posedge clk);
    #1;
    drive(1'b0, 1'b1);
    repeat (4 * B + B / 2) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("mid_rst_data", {24'd0, data}, 32'h00);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("mid_rst_seq", {31'd0, seq_err}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(3 * B);
    chk("mid_rst_hold", {24'd0, data}, 32'h00);
    sbq.push_back('{8'h81, 1'b0, SEQ_ON});
    send(1'b0, 8'h81, 1'b1);
    idle(2 * B);
    chk("post_rst_data", {24'd0, data}, 32'h81);
    chk("sb_empty", sbq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
